// File: rtl/pe_traffic_node_if.sv
// Local-port link between a NoC router and its processing-element traffic node.
// master = node side (drives tx data/valid and rx ready), slave = router side.
interface pe_traffic_node_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/pe_traffic_node.sv
// NoC PE traffic node: injects PKT_LIMIT packets {dest, src, seq} and counts received packets.
// Optional in-order receive checker with o_err_count is enabled by defining PE_RX_CHECK_EN.
//
// state   | meaning
// S_IDLE  | waiting for i_en
// S_DELAY | start-up idle cycles before the first packet
// S_SEND  | packet held on tx_data with tx_valid=1 until accepted
// S_GAP   | idle cycles after an accepted packet
// S_DONE  | all packets accepted; terminal until reset
module pe_traffic_node #(
  parameter int          ADDRESS     = 0,
  parameter int          NUM_PE      = 4,
  parameter int          DATA_W      = 32,
  parameter int          ADDR_W      = 8,
  parameter int          PKT_LIMIT   = 100,
  parameter int          START_DELAY = 12,
  parameter int          GAP         = 0,
  parameter int          MODE        = 0,
  parameter int          FIXED_DEST  = 0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  pe_traffic_node_if.master        io_noc,
  output logic                     o_tx_done,
  output logic [15:0]              o_tx_count,
  output logic [15:0]              o_rx_count
`ifdef PE_RX_CHECK_EN
  ,
  output logic [15:0]              o_err_count
`endif
);

  localparam int          SEQ_W      = DATA_W - 2*ADDR_W;
  localparam logic [15:0] SEED_RAW   = LFSR_SEED ^ 16'(ADDRESS);
  localparam logic [15:0] SEED       = (SEED_RAW == 16'h0) ? 16'h0001 : SEED_RAW;
  localparam logic [15:0] NUM_PE16   = 16'(NUM_PE);
  localparam logic [ADDR_W-1:0] SRC        = ADDR_W'(ADDRESS);
  localparam logic [ADDR_W-1:0] DEST_FIXED = ADDR_W'(FIXED_DEST);
  localparam logic [ADDR_W-1:0] RR_FIRST   = ADDR_W'((ADDRESS + 1) % NUM_PE);
  localparam logic [ADDR_W-1:0] RR_LAST    = ADDR_W'(NUM_PE - 1);
  localparam logic [15:0] LAST_IDX   = 16'(PKT_LIMIT - 1);
  localparam logic [15:0] DELAY_LOAD = 16'((START_DELAY > 0) ? START_DELAY - 1 : 0);
  localparam logic [15:0] GAP_LOAD   = 16'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_DELAY, S_SEND, S_GAP, S_DONE} state_t;

  state_t            r_state;
  logic [15:0]       r_timer;
  logic [15:0]       r_idx;
  logic [15:0]       r_lfsr;
  logic [ADDR_W-1:0] r_rr;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_done;
  logic [15:0]       r_tx_count;
  logic              r_rdy;
  logic [15:0]       r_rx_count;

  logic              w_accept;
  logic [15:0]       w_lfsr_nxt;
  logic [ADDR_W-1:0] w_rr_nxt;

  // Galois form of x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [ADDR_W-1:0] pick_dest(input logic [15:0] lfsr,
                                                  input logic [ADDR_W-1:0] rr);
    if (MODE == 0)      return ADDR_W'(lfsr % NUM_PE16);
    else if (MODE == 1) return rr;
    else                return DEST_FIXED;
  endfunction

  function automatic logic [DATA_W-1:0] make_pkt(input logic [15:0] idx,
                                                 input logic [15:0] lfsr,
                                                 input logic [ADDR_W-1:0] rr);
    return {pick_dest(lfsr, rr), SRC, SEQ_W'(idx)};
  endfunction

  assign w_accept   = r_valid & io_noc.tx_ready;
  assign w_lfsr_nxt = lfsr_step(r_lfsr);
  assign w_rr_nxt   = (r_rr == RR_LAST) ? '0 : r_rr + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_timer    <= '0;
      r_idx      <= '0;
      r_lfsr     <= SEED;
      r_rr       <= RR_FIRST;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_done     <= 1'b0;
      r_tx_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_en) begin
            if (START_DELAY == 0) begin
              r_state <= S_SEND;
              r_valid <= 1'b1;
              r_data  <= make_pkt(r_idx, r_lfsr, r_rr);
            end else begin
              r_state <= S_DELAY;
              r_timer <= DELAY_LOAD;
            end
          end
        end
        S_DELAY, S_GAP: begin
          if (r_timer == 16'd0) begin
            r_state <= S_SEND;
            r_valid <= 1'b1;
            r_data  <= make_pkt(r_idx, r_lfsr, r_rr);
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_SEND: begin
          if (w_accept) begin
            r_tx_count <= r_tx_count + 16'd1;
            r_idx      <= r_idx + 16'd1;
            r_lfsr     <= w_lfsr_nxt;
            r_rr       <= w_rr_nxt;
            if (r_idx == LAST_IDX) begin
              r_state <= S_DONE;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else if (GAP == 0) begin
              // back-to-back: next packet built from the post-accept index and LFSR
              r_data <= make_pkt(r_idx + 16'd1, w_lfsr_nxt, w_rr_nxt);
            end else begin
              r_state <= S_GAP;
              r_valid <= 1'b0;
              r_timer <= GAP_LOAD;
            end
          end
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdy      <= 1'b0;
      r_rx_count <= '0;
    end else begin
      r_rdy <= 1'b1;
      if (io_noc.rx_valid && (r_rx_count != 16'hFFFF)) r_rx_count <= r_rx_count + 16'd1;
    end
  end

`ifdef PE_RX_CHECK_EN
  localparam int PE_IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [SEQ_W-1:0]    r_exp [NUM_PE];
  logic [15:0]         r_err_count;
  logic [ADDR_W-1:0]   w_rx_dest;
  logic [ADDR_W-1:0]   w_rx_src;
  logic [SEQ_W-1:0]    w_rx_seq;
  logic [PE_IDX_W-1:0] w_src_idx;
  logic                w_src_ok;
  logic [SEQ_W-1:0]    w_exp_seq;
  logic                w_rx_err;

  assign w_rx_dest = io_noc.rx_data[DATA_W-1 -: ADDR_W];
  assign w_rx_src  = io_noc.rx_data[DATA_W-ADDR_W-1 -: ADDR_W];
  assign w_rx_seq  = io_noc.rx_data[SEQ_W-1:0];
  assign w_src_idx = PE_IDX_W'(w_rx_src);
  assign w_src_ok  = 32'(w_rx_src) < 32'(NUM_PE);
  assign w_exp_seq = w_src_ok ? r_exp[w_src_idx] : '0;
  assign w_rx_err  = !w_src_ok || (w_rx_dest != SRC) || (w_rx_seq != w_exp_seq);

  // Expected seq resyncs to seq+1 on every packet so one gap yields one error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_count <= '0;
      for (int i = 0; i < NUM_PE; i++) r_exp[i] <= '0;
    end else if (io_noc.rx_valid) begin
      if (w_rx_err && (r_err_count != 16'hFFFF)) r_err_count <= r_err_count + 16'd1;
      if (w_src_ok) r_exp[w_src_idx] <= w_rx_seq + 1'b1;
    end
  end

  assign o_err_count = r_err_count;
`else
  logic w_unused_rx;
  assign w_unused_rx = ^io_noc.rx_data;
`endif

  assign io_noc.tx_data  = r_data;
  assign io_noc.tx_valid = r_valid;
  assign io_noc.rx_ready = r_rdy;
  assign o_tx_done       = r_done;
  assign o_tx_count      = r_tx_count;
  assign o_rx_count      = r_rx_count;

endmodule

// File: tb/tb_pe_traffic_node.sv
// Bench for pe_traffic_node: three differently configured nodes checked every cycle against a
// packet-level model, plus directed scenarios with hand-computed expectations.
module tb_pe_traffic_node;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;
  always #5 clk = ~clk;

  logic        tb_rdy  [3];
  logic        tb_rxv  [3];
  logic [31:0] tb_rxd  [3];
  bit          rdy_rand[3];
  bit          rx_rand [3];

  logic [31:0] d_data [3];
  logic        d_valid[3];
  logic        d_rdy  [3];
  logic        d_done [3];
  logic [15:0] d_txc  [3];
  logic [15:0] d_rxc  [3];
`ifdef PE_RX_CHECK_EN
  logic [15:0] d_err  [3];
`endif

  pe_traffic_node_if #(.DATA_W(32)) if0();
  pe_traffic_node_if #(.DATA_W(32)) if1();
  pe_traffic_node_if #(.DATA_W(32)) if2();

  assign if0.tx_ready = tb_rdy[0];
  assign if0.rx_valid = tb_rxv[0];
  assign if0.rx_data  = tb_rxd[0];
  assign if1.tx_ready = tb_rdy[1];
  assign if1.rx_valid = tb_rxv[1];
  assign if1.rx_data  = tb_rxd[1];
  assign if2.tx_ready = tb_rdy[2];
  assign if2.rx_valid = tb_rxv[2];
  assign if2.rx_data  = tb_rxd[2];

  assign d_data[0] = if0.tx_data;  assign d_valid[0] = if0.tx_valid;  assign d_rdy[0] = if0.rx_ready;
  assign d_data[1] = if1.tx_data;  assign d_valid[1] = if1.tx_valid;  assign d_rdy[1] = if1.rx_ready;
  assign d_data[2] = if2.tx_data;  assign d_valid[2] = if2.tx_valid;  assign d_rdy[2] = if2.rx_ready;

  pe_traffic_node #(.ADDRESS(2), .NUM_PE(4), .DATA_W(32), .ADDR_W(8), .PKT_LIMIT(4),
                    .START_DELAY(12), .GAP(0), .MODE(1), .FIXED_DEST(0)) u0 (
    .clk(clk), .rst(rst), .i_en(en), .io_noc(if0),
    .o_tx_done(d_done[0]), .o_tx_count(d_txc[0]), .o_rx_count(d_rxc[0])
`ifdef PE_RX_CHECK_EN
    , .o_err_count(d_err[0])
`endif
  );

  pe_traffic_node #(.ADDRESS(1), .NUM_PE(4), .DATA_W(32), .ADDR_W(8), .PKT_LIMIT(6),
                    .START_DELAY(2), .GAP(3), .MODE(2), .FIXED_DEST(1)) u1 (
    .clk(clk), .rst(rst), .i_en(en), .io_noc(if1),
    .o_tx_done(d_done[1]), .o_tx_count(d_txc[1]), .o_rx_count(d_rxc[1])
`ifdef PE_RX_CHECK_EN
    , .o_err_count(d_err[1])
`endif
  );

  pe_traffic_node #(.ADDRESS(3), .NUM_PE(3), .DATA_W(32), .ADDR_W(8), .PKT_LIMIT(100),
                    .START_DELAY(0), .GAP(1), .MODE(0), .FIXED_DEST(0)) u2 (
    .clk(clk), .rst(rst), .i_en(en), .io_noc(if2),
    .o_tx_done(d_done[2]), .o_tx_count(d_txc[2]), .o_rx_count(d_rxc[2])
`ifdef PE_RX_CHECK_EN
    , .o_err_count(d_err[2])
`endif
  );

  // Configuration of each node, mirrored from the instantiations above
  function automatic int c_addr(int k); case (k) 0: return 2;  1: return 1; default: return 3;   endcase endfunction
  function automatic int c_num (int k); case (k) 0: return 4;  1: return 4; default: return 3;   endcase endfunction
  function automatic int c_mode(int k); case (k) 0: return 1;  1: return 2; default: return 0;   endcase endfunction
  function automatic int c_fd  (int k); case (k) 0: return 0;  1: return 1; default: return 0;   endcase endfunction
  function automatic int c_lim (int k); case (k) 0: return 4;  1: return 6; default: return 100; endcase endfunction
  function automatic int c_sd  (int k); case (k) 0: return 12; 1: return 2; default: return 0;   endcase endfunction
  function automatic int c_gap (int k); case (k) 0: return 0;  1: return 3; default: return 1;   endcase endfunction

  // Packet n of node k, from the packet-format and destination rules
  function automatic logic [31:0] m_pkt(int k, int n);
    logic [15:0] l;
    int dest;
    l = 16'hACE1 ^ 16'(c_addr(k));
    if (l == 16'h0) l = 16'h1;
    if (c_mode(k) == 0)
      for (int i = 0; i < n; i++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    case (c_mode(k))
      0:       dest = int'(l) % c_num(k);
      1:       dest = (c_addr(k) + 1 + n) % c_num(k);
      default: dest = c_fd(k);
    endcase
    return {8'(dest), 8'(c_addr(k)), 16'(n)};
  endfunction

  int edge_no = 0;
  int m_sent [3] = '{0, 0, 0};
  int m_nve  [3] = '{0, 0, 0};
  bit m_start[3] = '{0, 0, 0};
  int m_rx   [3] = '{0, 0, 0};
  bit m_rdy  [3] = '{0, 0, 0};

  // valid is expected from edge m_nve on, while packets remain
  function automatic bit m_valid(int k);
    return m_start[k] && (m_sent[k] < c_lim(k)) && (edge_no >= m_nve[k]);
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        m_sent[k]  <= 0;
        m_nve[k]   <= 0;
        m_start[k] <= 1'b0;
        m_rx[k]    <= 0;
        m_rdy[k]   <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (m_valid(k) && tb_rdy[k]) begin
          m_sent[k] <= m_sent[k] + 1;
          m_nve[k]  <= edge_no + 1 + c_gap(k);
        end else if (!m_start[k] && en) begin
          m_start[k] <= 1'b1;
          m_nve[k]   <= edge_no + 1 + c_sd(k);
        end
        if (tb_rxv[k] && m_rx[k] < 65535) m_rx[k] <= m_rx[k] + 1;
        m_rdy[k] <= 1'b1;
      end
      edge_no <= edge_no + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s node%0d: actual=%0h expected=%0h", nm, k, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("valid", k, 32'(d_valid[k]), 32'(m_valid(k)));
      if (m_valid(k)) chk("data", k, d_data[k], m_pkt(k, m_sent[k]));
      chk("tx_count", k, 32'(d_txc[k]), 32'(m_sent[k]));
      chk("tx_done", k, 32'(d_done[k]), 32'(m_sent[k] == c_lim(k)));
      chk("rx_count", k, 32'(d_rxc[k]), 32'(m_rx[k]));
      chk("rx_ready", k, 32'(d_rdy[k]), 32'(m_rdy[k]));
    end
  end

  logic [31:0] q0_d[$];
  int          q0_e[$];
  logic [31:0] q1_d[$];
  int          q1_e[$];
  logic [31:0] q2_d[$];

  always @(posedge clk) begin
    if (rst && d_valid[0] && tb_rdy[0]) begin q0_d.push_back(d_data[0]); q0_e.push_back(edge_no); end
    if (rst && d_valid[1] && tb_rdy[1]) begin q1_d.push_back(d_data[1]); q1_e.push_back(edge_no); end
    if (rst && d_valid[2] && tb_rdy[2]) q2_d.push_back(d_data[2]);
  end

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rdy_rand[k]) tb_rdy[k] = 1'($urandom_range(0, 1));
      if (rx_rand[k]) begin
        tb_rxv[k] = 1'($urandom_range(0, 1));
        tb_rxd[k] = $urandom;
      end
    end
  endtask

  initial begin
    int cnt;
    int base;
    logic [31:0] w;
    logic [31:0] hold;
    logic [15:0] hold_c;

    for (int k = 0; k < 3; k++) begin
      tb_rdy[k] = 1'b0; tb_rxv[k] = 1'b0; tb_rxd[k] = '0;
      rdy_rand[k] = 1'b0; rx_rand[k] = 1'b0;
    end
    rx_rand[1] = 1'b1;
    rx_rand[2] = 1'b1;

    chk("model_rr_pin", 0, m_pkt(0, 1), 32'h00020001);
    chk("model_lfsr_pin", 2, m_pkt(2, 2), 32'h02030002);

    // reset held with enable and random rx traffic
    en = 1'b1;
    repeat (6) tick();
    chk("rst_valid", 2, 32'(d_valid[2]), 0);
    chk("rst_txc", 2, 32'(d_txc[2]), 0);
    chk("rst_rxc", 1, 32'(d_rxc[1]), 0);
    chk("rst_ready", 1, 32'(d_rdy[1]), 0);
    en = 1'b0;
    #2 rst = 1'b1;
    repeat (3) tick();

    // start-up latency, round-robin destinations, back-to-back sends
    tb_rdy[0] = 1'b1;
    tb_rdy[1] = 1'b1;
    rdy_rand[2] = 1'b1;
    en = 1'b1;
    cnt = 0;
    while (!d_valid[0] && cnt < 40) begin tick(); cnt++; end
    chk("start_latency", 0, cnt, 13);
    cnt = 0;
    while (!d_done[0] && cnt < 20) begin tick(); cnt++; end
    chk("done_wait", 0, 32'(d_done[0]), 1);
    chk("tx_count_final", 0, 32'(d_txc[0]), 4);
    chk("accepts", 0, q0_d.size(), 4);
    if (q0_d.size() == 4) begin
      chk("pkt0", 0, q0_d[0], 32'h03020000);
      chk("pkt1", 0, q0_d[1], 32'h00020001);
      chk("pkt2", 0, q0_d[2], 32'h01020002);
      chk("pkt3", 0, q0_d[3], 32'h02020003);
      for (int i = 1; i < 4; i++) chk("b2b_spacing", 0, q0_e[i] - q0_e[i-1], 1);
    end

    // fixed destination with a three-cycle gap
    cnt = 0;
    while (!d_done[1] && cnt < 60) begin tick(); cnt++; end
    chk("gap_done_wait", 1, 32'(d_done[1]), 1);
    chk("gap_accepts", 1, q1_d.size(), 6);
    for (int i = 0; i < q1_d.size(); i++) begin
      w = q1_d[i];
      chk("fixed_dest", 1, 32'(w[31:24]), 1);
      chk("gap_seq", 1, 32'(w[15:0]), i);
      if (i > 0) chk("gap_spacing", 1, q1_e[i] - q1_e[i-1], 4);
    end

    // LFSR destinations of node 2
    cnt = 0;
    while (q2_d.size() < 3 && cnt < 40) begin tick(); cnt++; end
    chk("lfsr_accepts", 2, 32'(q2_d.size() >= 3), 1);
    if (q2_d.size() >= 3) begin
      chk("lfsr_pkt0", 2, q2_d[0], 32'h02030000);
      chk("lfsr_pkt1", 2, q2_d[1], 32'h01030001);
      chk("lfsr_pkt2", 2, q2_d[2], 32'h02030002);
    end

    // backpressure: ready low for 5 cycles while a packet is offered
    rdy_rand[2] = 1'b0;
    tb_rdy[2] = 1'b0;
    cnt = 0;
    while (!d_valid[2] && cnt < 10) begin tick(); cnt++; end
    chk("bp_valid_seen", 2, 32'(d_valid[2]), 1);
    hold = d_data[2];
    hold_c = d_txc[2];
    repeat (5) begin
      tick();
      chk("bp_data_stable", 2, d_data[2], hold);
      chk("bp_valid_held", 2, 32'(d_valid[2]), 1);
      chk("bp_count_held", 2, 32'(d_txc[2]), 32'(hold_c));
    end
    rdy_rand[2] = 1'b1;

    // rx counting and in-order checking on node 0
    base = d_rxc[0];
    for (int s = 0; s < 10; s++) begin
      tb_rxv[0] = 1'b1;
      tb_rxd[0] = {8'd2, 8'd1, 16'(s)};
      tick();
    end
    tb_rxd[0] = {8'd2, 8'd1, 16'd12};
    tick();
    tb_rxv[0] = 1'b0;
    tick();
    chk("rx_count_11", 0, 32'(d_rxc[0]), 32'(base + 11));
`ifdef PE_RX_CHECK_EN
    chk("err_after_gap", 0, 32'(d_err[0]), 1);
`endif
    tb_rxv[0] = 1'b1;
    tb_rxd[0] = {8'd2, 8'd1, 16'd13};
    tick();
    tb_rxv[0] = 1'b0;
    tick();
    chk("rx_count_12", 0, 32'(d_rxc[0]), 32'(base + 12));
`ifdef PE_RX_CHECK_EN
    chk("err_after_resync", 0, 32'(d_err[0]), 1);
`endif

    // reset while node 2 is offering a packet, then restart
    cnt = 0;
    while (!d_valid[2] && cnt < 50) begin tick(); cnt++; end
    chk("mid_send_valid", 2, 32'(d_valid[2]), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_valid_drop", 2, 32'(d_valid[2]), 0);
    chk("async_txc_clear", 2, 32'(d_txc[2]), 0);
    q2_d.delete();
    en = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    tick();
    en = 1'b1;
    cnt = 0;
    while (q2_d.size() < 3 && cnt < 100) begin tick(); cnt++; end
    chk("restart_accepts", 2, 32'(q2_d.size() >= 3), 1);
    if (q2_d.size() >= 3) begin
      chk("restart_pkt0", 2, q2_d[0], 32'h02030000);
      chk("restart_pkt1", 2, q2_d[1], 32'h01030001);
      chk("restart_pkt2", 2, q2_d[2], 32'h02030002);
    end
    repeat (300) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
